// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS-lite datapath: FETCH/DCD/EXE/MA/WB sequencing.
// Optional addi support with overflow-suppressed write-back is enabled by defining CTRL_ADDI_EN.
module mc_ctrl #(
  parameter int ST_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            ovf,
  input  logic            dm_rdy,
  output logic            PCWr,
  output logic            IRWr,
  output logic            RegWr,
  output logic            DMWr,
  output logic            DMRd,
  output logic [1:0]      ExtOp,
  output logic            ALUSrc,
  output logic [1:0]      ALUOp,
  output logic [1:0]      RegDst,
  output logic [1:0]      WDSel,
  output logic [1:0]      NPCOp,
  output logic            illegal,
  output logic            done,
  output logic [ST_W-1:0] state
);

  typedef enum logic [ST_W-1:0] {
    S_FETCH = ST_W'(0),
    S_DCD   = ST_W'(1),
    S_EXE   = ST_W'(2),
    S_MA    = ST_W'(3),
    S_WB    = ST_W'(4)
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_JR    = 6'b001000;

  state_t state_q;
  state_t state_d;

  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lw, is_sw;
  logic is_beq, is_lui, is_j, is_jal, is_addi, legal;

  assign is_r    = (op == OP_R);
  assign is_addu = is_r && (funct == F_ADDU);
  assign is_subu = is_r && (funct == F_SUBU);
  assign is_jr   = is_r && (funct == F_JR);
  assign is_ori  = (op == OP_ORI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_lui  = (op == OP_LUI);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);

`ifdef CTRL_ADDI_EN
  logic ovf_q;

  assign is_addi = (op == 6'b001000);

  // Overflow is captured at the end of EXE so WB can suppress the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_EXE) begin
      ovf_q <= ovf;
    end
  end
`else
  logic ovf_unused;

  assign is_addi    = 1'b0;
  assign ovf_unused = ovf;
`endif

  assign legal = is_addu | is_subu | is_jr | is_ori | is_lw | is_sw |
                 is_beq | is_lui | is_j | is_jal | is_addi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // Everything is held at zero while reset is asserted, independent of state.
  always_comb begin
    state_d = S_FETCH;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RegWr   = 1'b0;
    DMWr    = 1'b0;
    DMRd    = 1'b0;
    ExtOp   = 2'b00;
    ALUSrc  = 1'b0;
    ALUOp   = 2'b00;
    RegDst  = 2'b00;
    WDSel   = 2'b00;
    NPCOp   = 2'b00;
    illegal = 1'b0;
    done    = 1'b0;
    if (rst_n) begin
      if (is_lw || is_sw || is_beq || is_addi) begin
        ExtOp = 2'b01;
      end else if (is_lui) begin
        ExtOp = 2'b10;
      end
      ALUSrc = is_ori | is_lw | is_sw | is_lui | is_addi;
      if (is_subu || is_beq) begin
        ALUOp = 2'b01;
      end else if (is_ori || is_lui) begin
        ALUOp = 2'b10;
      end

      case (state_q)
        S_FETCH: begin
          PCWr    = 1'b1;
          IRWr    = 1'b1;
          state_d = S_DCD;
        end
        S_DCD: begin
          if (is_j || is_jal) begin
            PCWr  = 1'b1;
            NPCOp = 2'b10;
            done  = 1'b1;
            if (is_jal) begin
              RegWr  = 1'b1;
              RegDst = 2'b10;
              WDSel  = 2'b10;
            end
          end else if (is_jr) begin
            PCWr  = 1'b1;
            NPCOp = 2'b11;
            done  = 1'b1;
          end else if (!legal) begin
            illegal = 1'b1;
            done    = 1'b1;
          end else begin
            state_d = S_EXE;
          end
        end
        S_EXE: begin
          if (is_beq) begin
            PCWr  = zero;
            NPCOp = 2'b01;
            done  = 1'b1;
          end else if (is_lw || is_sw) begin
            state_d = S_MA;
          end else begin
            state_d = S_WB;
          end
        end
        S_MA: begin
          if (is_sw) begin
            DMWr = 1'b1;
            if (dm_rdy) begin
              done = 1'b1;
            end else begin
              state_d = S_MA;
            end
          end else begin
            DMRd    = 1'b1;
            state_d = dm_rdy ? S_WB : S_MA;
          end
        end
        S_WB: begin
`ifdef CTRL_ADDI_EN
          RegWr = is_addi ? ~ovf_q : 1'b1;
`else
          RegWr = 1'b1;
`endif
          done   = 1'b1;
          RegDst = is_r ? 2'b01 : 2'b00;
          WDSel  = is_lw ? 2'b01 : 2'b00;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction cycle traces from a table-level model of the ISA timing.
// Build with CTRL_ADDI_EN defined to also cover addi.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, ovf, dm_rdy;
  logic       PCWr, IRWr, RegWr, DMWr, DMRd, ALUSrc, illegal, done;
  logic [1:0] ExtOp, ALUOp, RegDst, WDSel, NPCOp;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  mc_ctrl #(.ST_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .ovf(ovf),
    .dm_rdy(dm_rdy), .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .DMWr(DMWr),
    .DMRd(DMRd), .ExtOp(ExtOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegDst(RegDst),
    .WDSel(WDSel), .NPCOp(NPCOp), .illegal(illegal), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // One expected cycle: state, enables, cycle-dependent selects, plus the inputs to drive.
  typedef struct packed {
    logic [2:0] st;
    logic       pcwr, irwr, regwr, dmwr, dmrd, ill, dn;
    logic [1:0] npc, rdst, wds;
    logic       zin, rin, oin;
  } cyc_t;

  cyc_t exp_q[$];

  localparam int C_ILL = 0, C_J = 1, C_JAL = 2, C_JR = 3, C_BEQ = 4;
  localparam int C_ALUR = 5, C_ALUI = 6, C_LW = 7, C_SW = 8, C_ADDI = 9;

  function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b000000: begin
        if (f == 6'b100001 || f == 6'b100011) return C_ALUR;
        if (f == 6'b001000) return C_JR;
        return C_ILL;
      end
      6'b001101, 6'b001111: return C_ALUI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
`ifdef CTRL_ADDI_EN
      6'b001000: return C_ADDI;
`endif
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [4:0] sel_exp(input logic [5:0] o, input logic [5:0] f);
    logic [1:0] ext, aop;
    logic       src;
    int         cls;
    cls = cls_of(o, f);
    ext = 2'b00;
    if (cls == C_LW || cls == C_SW || cls == C_BEQ || cls == C_ADDI) ext = 2'b01;
    if (o == 6'b001111) ext = 2'b10;
    src = (cls == C_ALUI || cls == C_LW || cls == C_SW || cls == C_ADDI);
    aop = 2'b00;
    if ((o == 6'b000000 && f == 6'b100011) || o == 6'b000100) aop = 2'b01;
    if (o == 6'b001101 || o == 6'b001111) aop = 2'b10;
    return {ext, src, aop};
  endfunction

  function automatic cyc_t blank(input logic [2:0] s);
    cyc_t c;
    c     = '0;
    c.st  = s;
    c.zin = 1'($urandom_range(0, 1));
    c.rin = 1'($urandom_range(0, 1));
    c.oin = 1'($urandom_range(0, 1));
    return c;
  endfunction

  // Instruction-level timing model: FETCH, then class-specific tail.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int w, input logic ov);
    cyc_t c;
    int   cls;
    cls = cls_of(o, f);
    c = blank(3'd0); c.pcwr = 1; c.irwr = 1; exp_q.push_back(c);
    c = blank(3'd1);
    case (cls)
      C_J:   begin c.pcwr = 1; c.npc = 2'b10; c.dn = 1; exp_q.push_back(c); end
      C_JAL: begin
        c.pcwr = 1; c.npc = 2'b10; c.dn = 1; c.regwr = 1; c.rdst = 2'b10; c.wds = 2'b10;
        exp_q.push_back(c);
      end
      C_JR:  begin c.pcwr = 1; c.npc = 2'b11; c.dn = 1; exp_q.push_back(c); end
      C_ILL: begin c.ill = 1; c.dn = 1; exp_q.push_back(c); end
      default: begin
        exp_q.push_back(c);
        c = blank(3'd2);
        if (cls == C_BEQ) begin
          c.zin = z; c.pcwr = z; c.npc = 2'b01; c.dn = 1;
          exp_q.push_back(c);
        end else if (cls == C_LW || cls == C_SW) begin
          exp_q.push_back(c);
          for (int i = 0; i <= w; i++) begin
            c = blank(3'd3);
            c.rin = (i == w);
            if (cls == C_LW) c.dmrd = 1;
            else begin c.dmwr = 1; c.dn = (i == w); end
            exp_q.push_back(c);
          end
          if (cls == C_LW) begin
            c = blank(3'd4); c.regwr = 1; c.wds = 2'b01; c.dn = 1;
            exp_q.push_back(c);
          end
        end else begin
          c.oin = ov;
          exp_q.push_back(c);
          c = blank(3'd4);
          c.regwr = (cls == C_ADDI) ? ~ov : 1'b1;
          c.rdst  = (cls == C_ALUR) ? 2'b01 : 2'b00;
          c.dn    = 1;
          exp_q.push_back(c);
        end
      end
    endcase
  endtask

  // Called just after a rising edge; plays up to lim expected cycles.
  task automatic run_trace(input int lim, input logic [5:0] o, input logic [5:0] f,
                           input string name);
    cyc_t        c;
    logic [20:0] act, ex;
    int          n;
    n = 0;
    while (exp_q.size() > 0 && n < lim) begin
      c      = exp_q.pop_front();
      op     = o;
      funct  = f;
      zero   = c.zin;
      dm_rdy = c.rin;
      ovf    = c.oin;
      @(negedge clk);
      act = {state, PCWr, IRWr, RegWr, DMWr, DMRd, illegal, done, NPCOp, RegDst, WDSel,
             ExtOp, ALUSrc, ALUOp};
      ex  = {c.st, c.pcwr, c.irwr, c.regwr, c.dmwr, c.dmrd, c.ill, c.dn, c.npc, c.rdst,
             c.wds, sel_exp(o, f)};
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h (op=%b funct=%b)",
                 name, n, act, ex, o, f);
      end
      n++;
      @(posedge clk);
      #1;
    end
    exp_q.delete();
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                          input int w, input logic ov, input string name);
    build(o, f, z, w, ov);
    run_trace(1000, o, f, name);
  endtask

  task automatic check_all_zero(input string name);
    logic [20:0] act;
    act = {state, PCWr, IRWr, RegWr, DMWr, DMRd, illegal, done, NPCOp, RegDst, WDSel,
           ExtOp, ALUSrc, ALUOp};
    checks++;
    if (act !== 21'd0) begin
      errors++;
      $display("FAIL %s: got %h expected 0", name, act);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    op = 6'b100011; funct = 6'b100001; zero = 1; ovf = 1; dm_rdy = 1;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset_hold");
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_ori();
    do_instr(6'b001101, 6'($urandom), 0, 0, 0, "ori");
  endtask

  task automatic test_lw();
    do_instr(6'b100011, 6'($urandom), 0, 2, 0, "lw_wait2");
    do_instr(6'b100011, 6'($urandom), 0, 0, 0, "lw_nowait");
  endtask

  task automatic test_beq();
    do_instr(6'b000100, 6'($urandom), 0, 0, 0, "beq_z0");
    do_instr(6'b000100, 6'($urandom), 1, 0, 0, "beq_z1");
  endtask

  task automatic test_jumps();
    do_instr(6'b001111, 6'($urandom), 0, 0, 0, "lui");
    do_instr(6'b000011, 6'($urandom), 0, 0, 0, "jal");
    do_instr(6'b000010, 6'($urandom), 0, 0, 0, "j");
    do_instr(6'b000000, 6'b001000, 0, 0, 0, "jr");
    do_instr(6'b000000, 6'b100001, 0, 0, 0, "addu");
    do_instr(6'b000000, 6'b100011, 0, 0, 0, "subu");
    do_instr(6'b101011, 6'($urandom), 0, 3, 0, "sw_wait3");
  endtask

  task automatic test_illegal();
    do_instr(6'b111111, 6'($urandom), 0, 0, 0, "illegal_op");
    do_instr(6'b000000, 6'b000000, 0, 0, 0, "illegal_funct");
  endtask

  task automatic test_addi();
    do_instr(6'b001000, 6'($urandom), 0, 0, 1, "addi_ovf1");
    do_instr(6'b001000, 6'($urandom), 0, 0, 0, "addi_ovf0");
  endtask

  task automatic test_reset_mid_sw();
    build(6'b101011, 6'd0, 0, 5, 0);
    run_trace(4, 6'b101011, 6'd0, "sw_pre_reset");
    dm_rdy = 1'b0;
    #2;
    checks++;
    if (DMWr !== 1'b1 || state !== 3'd3) begin
      errors++;
      $display("FAIL sw_in_ma: got DMWr=%b state=%0d expected DMWr=1 state=3", DMWr, state);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_sw");
    @(posedge clk);
    #1;
    check_all_zero("reset_mid_sw_held");
    rst_n = 1'b1;
    do_instr(6'b001101, 6'd0, 0, 0, 0, "ori_after_reset");
  endtask

  task automatic test_random();
    logic [11:0] tbl [11];
    logic [5:0]  o, f;
    int          k;
    tbl = '{12'b000000_100001, 12'b000000_100011, 12'b000000_001000, 12'b001101_000000,
            12'b100011_000000, 12'b101011_000000, 12'b000100_000000, 12'b001111_000000,
            12'b000010_000000, 12'b000011_000000, 12'b001000_000000};
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        o = 6'($urandom);
        f = 6'($urandom);
      end else begin
        k = $urandom_range(0, 10);
        o = tbl[k][11:6];
        f = (o == 6'b000000) ? tbl[k][5:0] : 6'($urandom);
      end
      do_instr(o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_ori();
    test_lw();
    test_beq();
    test_jumps();
    test_illegal();
    test_addi();
    test_reset_mid_sw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
